// File: rtl/reg_wb_unit_if.sv
// Bus bundle between the pipeline and the register-file writeback unit.
// The unit owns the ready/busy/writeback side; the pipeline drives the rest.
interface reg_wb_unit_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned LQ_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;

  // ALU result offer
  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_result;

  // Load issue and in-order response
  logic              ld_issue_valid;
  logic              ld_issue_ready;
  logic [REG_AW-1:0] ld_issue_rd;
  logic              ld_resp_valid;
  logic [XLEN-1:0]   ld_resp_data;

  // Decode hazard query
  logic [REG_AW-1:0] chk_rs1;
  logic [REG_AW-1:0] chk_rs2;
  logic              rs1_busy;
  logic              rs2_busy;

  // Register-file write port and status
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_result;
  logic              wb_reg_write;
  logic [CNT_W-1:0]  lq_count;
  logic              ld_err;

  modport master (
    output alu_valid, alu_rd, alu_result,
    output ld_issue_valid, ld_issue_rd, ld_resp_valid, ld_resp_data,
    output chk_rs1, chk_rs2,
    input  alu_ready, ld_issue_ready, rs1_busy, rs2_busy,
    input  wb_rd, wb_result, wb_reg_write, lq_count, ld_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  ld_issue_valid, ld_issue_rd, ld_resp_valid, ld_resp_data,
    input  chk_rs1, chk_rs2,
    output alu_ready, ld_issue_ready, rs1_busy, rs2_busy,
    output wb_rd, wb_result, wb_reg_write, lq_count, ld_err
  );
endinterface

// File: rtl/reg_wb_unit.sv
// Integer register-file writeback: merges ALU results and in-order load
// responses onto one write port, tracking pending loads for hazard stalls.
module reg_wb_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned LQ_DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  reg_wb_unit_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(LQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wr_entry_t;

  // Load queue holds only destination registers; data arrives with the response.
  logic [REG_AW-1:0] lq_rd [LQ_DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_nxt;
  logic [NREG-1:0]   busy_q, busy_nxt;

  logic              skid_valid_q, skid_valid_nxt;
  wr_entry_t         skid_q, skid_nxt;

  logic [REG_AW-1:0] wb_rd_q;
  logic [XLEN-1:0]   wb_result_q;
  logic              wb_reg_write_q;
  logic              ld_err_q;

  logic              lq_empty_c;
  logic              ld_pop_c;
  logic              alu_ready_c;
  logic              alu_fire_c;
  logic              issue_ready_c;
  logic              issue_fire_c;
  logic [REG_AW-1:0] head_rd_c;

  logic              sel_valid_c;
  wr_entry_t         sel_c;

  // Handshake qualification from current state only
  always_comb begin
    lq_empty_c    = (count_q == '0);
    head_rd_c     = lq_rd[head_q];
    ld_pop_c      = bus.ld_resp_valid && !lq_empty_c;
    alu_ready_c   = !skid_valid_q && !busy_q[bus.alu_rd];
    alu_fire_c    = bus.alu_valid && alu_ready_c;
    issue_ready_c = (count_q < CNT_W'(LQ_DEPTH)) && !busy_q[bus.ld_issue_rd];
    issue_fire_c  = bus.ld_issue_valid && issue_ready_c;
  end

  // Writeback source select: load response, then skid, then direct ALU
  always_comb begin
    sel_valid_c = 1'b0;
    sel_c       = '0;
    if (ld_pop_c) begin
      sel_valid_c = 1'b1;
      sel_c.rd    = head_rd_c;
      sel_c.data  = bus.ld_resp_data;
    end else if (skid_valid_q) begin
      sel_valid_c = 1'b1;
      sel_c       = skid_q;
    end else if (alu_fire_c) begin
      sel_valid_c = 1'b1;
      sel_c.rd    = bus.alu_rd;
      sel_c.data  = bus.alu_result;
    end
  end

  // Skid captures an ALU result that lost arbitration to a load response
  always_comb begin
    skid_valid_nxt = skid_valid_q;
    skid_nxt       = skid_q;
    if (alu_fire_c && ld_pop_c) begin
      skid_valid_nxt = 1'b1;
      skid_nxt.rd    = bus.alu_rd;
      skid_nxt.data  = bus.alu_result;
    end else if (skid_valid_q && !ld_pop_c) begin
      skid_valid_nxt = 1'b0;
    end
  end

  // Scoreboard and occupancy update; x0 is never marked busy
  always_comb begin
    busy_nxt = busy_q;
    if (ld_pop_c) busy_nxt[head_rd_c] = 1'b0;
    if (issue_fire_c && (bus.ld_issue_rd != '0)) busy_nxt[bus.ld_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;

    count_nxt = count_q;
    case ({issue_fire_c, ld_pop_c})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LQ_DEPTH); i++) lq_rd[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      skid_valid_q   <= 1'b0;
      skid_q         <= '0;
      wb_rd_q        <= '0;
      wb_result_q    <= '0;
      wb_reg_write_q <= 1'b0;
      ld_err_q       <= 1'b0;
    end else begin
      if (issue_fire_c) begin
        lq_rd[tail_q] <= bus.ld_issue_rd;
        tail_q        <= tail_q + PTR_W'(1);
      end
      if (ld_pop_c) head_q <= head_q + PTR_W'(1);
      count_q      <= count_nxt;
      busy_q       <= busy_nxt;
      skid_valid_q <= skid_valid_nxt;
      skid_q       <= skid_nxt;

      // A write to x0 is consumed but never reaches the register file
      if (sel_valid_c) begin
        wb_rd_q        <= sel_c.rd;
        wb_result_q    <= sel_c.data;
        wb_reg_write_q <= (sel_c.rd != '0);
      end else begin
        wb_reg_write_q <= 1'b0;
      end

      if (bus.ld_resp_valid && lq_empty_c) ld_err_q <= 1'b1;
    end
  end

  // Hazard query covers scoreboard, skid and the in-flight output stage
  always_comb begin
    bus.rs1_busy = (bus.chk_rs1 != '0) &&
                   (busy_q[bus.chk_rs1] ||
                    (skid_valid_q && (skid_q.rd == bus.chk_rs1)) ||
                    (wb_reg_write_q && (wb_rd_q == bus.chk_rs1)));
    bus.rs2_busy = (bus.chk_rs2 != '0) &&
                   (busy_q[bus.chk_rs2] ||
                    (skid_valid_q && (skid_q.rd == bus.chk_rs2)) ||
                    (wb_reg_write_q && (wb_rd_q == bus.chk_rs2)));
  end

  assign bus.alu_ready      = alu_ready_c;
  assign bus.ld_issue_ready = issue_ready_c;
  assign bus.wb_rd          = wb_rd_q;
  assign bus.wb_result      = wb_result_q;
  assign bus.wb_reg_write   = wb_reg_write_q;
  assign bus.lq_count       = count_q;
  assign bus.ld_err         = ld_err_q;

endmodule

// File: tb/tb_reg_wb_unit.sv
// Directed self-checking bench for reg_wb_unit.
module tb_reg_wb_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  reg_wb_unit_if #(.XLEN(32), .REG_AW(4), .LQ_DEPTH(4)) bus ();

  reg_wb_unit #(.XLEN(32), .REG_AW(4), .LQ_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid      = 1'b0;
    bus.alu_rd         = '0;
    bus.alu_result     = '0;
    bus.ld_issue_valid = 1'b0;
    bus.ld_issue_rd    = '0;
    bus.ld_resp_valid  = 1'b0;
    bus.ld_resp_data   = '0;
    bus.chk_rs1        = '0;
    bus.chk_rs2        = '0;
  endtask

  task automatic issue_load(input logic [3:0] rd);
    bus.ld_issue_valid = 1'b1;
    bus.ld_issue_rd    = rd;
    #1;
    checks++; if (bus.ld_issue_ready !== 1'b1) begin failures++; $display("FAIL issue_ready rd=%0d got=%b exp=1", rd, bus.ld_issue_ready); end
    tick();
    bus.ld_issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++; if (bus.wb_reg_write !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", bus.wb_reg_write); end
    checks++; if (bus.wb_rd !== 4'd0) begin failures++; $display("FAIL rst_rd got=%0d exp=0", bus.wb_rd); end
    checks++; if (bus.wb_result !== 32'd0) begin failures++; $display("FAIL rst_result got=%h exp=0", bus.wb_result); end
    checks++; if (bus.lq_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.lq_count); end
    checks++; if (bus.ld_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.ld_err); end
    checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL rst_alu_ready got=%b exp=1", bus.alu_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd3; bus.alu_result = 32'h1234;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL alu_ready got=%b exp=1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    checks++; if (bus.wb_reg_write !== 1'b1) begin failures++; $display("FAIL alu_we got=%b exp=1", bus.wb_reg_write); end
    checks++; if (bus.wb_rd !== 4'd3) begin failures++; $display("FAIL alu_rd got=%0d exp=3", bus.wb_rd); end
    checks++; if (bus.wb_result !== 32'h1234) begin failures++; $display("FAIL alu_result got=%h exp=1234", bus.wb_result); end
    tick();
    checks++; if (bus.wb_reg_write !== 1'b0) begin failures++; $display("FAIL alu_we_drop got=%b exp=0", bus.wb_reg_write); end
    checks++; if (bus.wb_rd !== 4'd3) begin failures++; $display("FAIL alu_rd_hold got=%0d exp=3", bus.wb_rd); end
  endtask

  task automatic test_collision();
    issue_load(4'd5);
    checks++; if (bus.lq_count !== 3'd1) begin failures++; $display("FAIL col_count got=%0d exp=1", bus.lq_count); end
    bus.chk_rs1 = 4'd5;
    #1;
    checks++; if (bus.rs1_busy !== 1'b1) begin failures++; $display("FAIL col_rs1_busy got=%b exp=1", bus.rs1_busy); end
    bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'hDEAD;
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd6; bus.alu_result = 32'h77;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL col_alu_ready0 got=%b exp=1", bus.alu_ready); end
    tick();
    bus.ld_resp_valid = 1'b0; bus.alu_valid = 1'b0; bus.chk_rs1 = 4'd6;
    #1;
    checks++; if (bus.wb_reg_write !== 1'b1 || bus.wb_rd !== 4'd5 || bus.wb_result !== 32'hDEAD) begin failures++; $display("FAIL col_wb1 got=%b/%0d/%h exp=1/5/dead", bus.wb_reg_write, bus.wb_rd, bus.wb_result); end
    checks++; if (bus.alu_ready !== 1'b0) begin failures++; $display("FAIL col_alu_ready1 got=%b exp=0", bus.alu_ready); end
    checks++; if (bus.rs1_busy !== 1'b1) begin failures++; $display("FAIL col_skid_busy got=%b exp=1", bus.rs1_busy); end
    checks++; if (bus.lq_count !== 3'd0) begin failures++; $display("FAIL col_count0 got=%0d exp=0", bus.lq_count); end
    tick();
    checks++; if (bus.wb_reg_write !== 1'b1 || bus.wb_rd !== 4'd6 || bus.wb_result !== 32'h77) begin failures++; $display("FAIL col_wb2 got=%b/%0d/%h exp=1/6/77", bus.wb_reg_write, bus.wb_rd, bus.wb_result); end
    checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL col_alu_ready2 got=%b exp=1", bus.alu_ready); end
    tick();
    checks++; if (bus.wb_reg_write !== 1'b0) begin failures++; $display("FAIL col_we_drop got=%b exp=0", bus.wb_reg_write); end
    bus.chk_rs1 = '0;
  endtask

  task automatic test_queue_full();
    for (int i = 1; i <= 4; i++) issue_load(4'(i));
    checks++; if (bus.lq_count !== 3'd4) begin failures++; $display("FAIL qf_count got=%0d exp=4", bus.lq_count); end
    bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 4'd8;
    #1;
    checks++; if (bus.ld_issue_ready !== 1'b0) begin failures++; $display("FAIL qf_ready got=%b exp=0", bus.ld_issue_ready); end
    bus.ld_issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ld_resp_valid = 1'b1;
      bus.ld_resp_data  = 32'hA000_0000 + 32'(i);
      bus.chk_rs1       = 4'(i + 1);
      #1;
      checks++; if (bus.rs1_busy !== 1'b1) begin failures++; $display("FAIL qf_busy_%0d got=%b exp=1", i + 1, bus.rs1_busy); end
      tick();
      checks++; if (bus.wb_reg_write !== 1'b1 || bus.wb_rd !== 4'(i + 1) || bus.wb_result !== 32'hA000_0000 + 32'(i)) begin failures++; $display("FAIL qf_wb_%0d got=%b/%0d/%h", i + 1, bus.wb_reg_write, bus.wb_rd, bus.wb_result); end
      checks++; if (bus.lq_count !== 3'(3 - i)) begin failures++; $display("FAIL qf_count_%0d got=%0d exp=%0d", i, bus.lq_count, 3 - i); end
    end
    bus.ld_resp_valid = 1'b0;
    bus.chk_rs1 = 4'd1;
    #1;
    checks++; if (bus.rs1_busy !== 1'b0) begin failures++; $display("FAIL qf_busy_clear got=%b exp=0", bus.rs1_busy); end
    tick();
    bus.chk_rs1 = '0;
  endtask

  task automatic test_hazard();
    issue_load(4'd7);
    bus.chk_rs1 = 4'd7;
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd7; bus.alu_result = 32'h55;
    bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 4'd7;
    #1;
    checks++; if (bus.alu_ready !== 1'b0) begin failures++; $display("FAIL hz_alu_stall got=%b exp=0", bus.alu_ready); end
    checks++; if (bus.rs1_busy !== 1'b1) begin failures++; $display("FAIL hz_rs1 got=%b exp=1", bus.rs1_busy); end
    checks++; if (bus.ld_issue_ready !== 1'b0) begin failures++; $display("FAIL hz_issue_stall got=%b exp=0", bus.ld_issue_ready); end
    bus.ld_issue_valid = 1'b0;
    bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'h700;
    tick();
    bus.ld_resp_valid = 1'b0;
    checks++; if (bus.wb_reg_write !== 1'b1 || bus.wb_rd !== 4'd7 || bus.wb_result !== 32'h700) begin failures++; $display("FAIL hz_ld_wb got=%b/%0d/%h exp=1/7/700", bus.wb_reg_write, bus.wb_rd, bus.wb_result); end
    checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL hz_alu_free got=%b exp=1", bus.alu_ready); end
    checks++; if (bus.rs1_busy !== 1'b1) begin failures++; $display("FAIL hz_rs1_wb got=%b exp=1", bus.rs1_busy); end
    tick();
    bus.alu_valid = 1'b0;
    checks++; if (bus.wb_reg_write !== 1'b1 || bus.wb_rd !== 4'd7 || bus.wb_result !== 32'h55) begin failures++; $display("FAIL hz_alu_wb got=%b/%0d/%h exp=1/7/55", bus.wb_reg_write, bus.wb_rd, bus.wb_result); end
    tick();
    checks++; if (bus.rs1_busy !== 1'b0) begin failures++; $display("FAIL hz_rs1_idle got=%b exp=0", bus.rs1_busy); end
    bus.chk_rs1 = '0;
  endtask

  task automatic test_x0();
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd0; bus.alu_result = 32'h99;
    tick();
    bus.alu_valid = 1'b0;
    checks++; if (bus.wb_reg_write !== 1'b0) begin failures++; $display("FAIL x0_alu_we got=%b exp=0", bus.wb_reg_write); end
    issue_load(4'd0);
    bus.chk_rs2 = 4'd0;
    #1;
    checks++; if (bus.lq_count !== 3'd1) begin failures++; $display("FAIL x0_count got=%0d exp=1", bus.lq_count); end
    checks++; if (bus.rs2_busy !== 1'b0) begin failures++; $display("FAIL x0_rs2 got=%b exp=0", bus.rs2_busy); end
    bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'hBEEF;
    tick();
    bus.ld_resp_valid = 1'b0;
    checks++; if (bus.wb_reg_write !== 1'b0) begin failures++; $display("FAIL x0_ld_we got=%b exp=0", bus.wb_reg_write); end
    checks++; if (bus.lq_count !== 3'd0) begin failures++; $display("FAIL x0_pop got=%0d exp=0", bus.lq_count); end
    checks++; if (bus.ld_err !== 1'b0) begin failures++; $display("FAIL x0_err got=%b exp=0", bus.ld_err); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 4'(11 + i); bus.alu_result = 32'hC0 + 32'(i);
      tick();
      checks++; if (bus.wb_reg_write !== 1'b1 || bus.wb_rd !== 4'(11 + i) || bus.wb_result !== 32'hC0 + 32'(i)) begin failures++; $display("FAIL b2b_%0d got=%b/%0d/%h", i, bus.wb_reg_write, bus.wb_rd, bus.wb_result); end
    end
    bus.alu_valid = 1'b0;
    tick();
  endtask

  task automatic test_error();
    bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'h1;
    tick();
    bus.ld_resp_valid = 1'b0;
    checks++; if (bus.wb_reg_write !== 1'b0) begin failures++; $display("FAIL err_we got=%b exp=0", bus.wb_reg_write); end
    checks++; if (bus.ld_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", bus.ld_err); end
    tick();
    checks++; if (bus.ld_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", bus.ld_err); end
  endtask

  task automatic test_reset_mid();
    issue_load(4'd9);
    issue_load(4'd10);
    checks++; if (bus.lq_count !== 3'd2) begin failures++; $display("FAIL rm_count_pre got=%0d exp=2", bus.lq_count); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.chk_rs1 = 4'd9; bus.chk_rs2 = 4'd10; bus.ld_issue_rd = 4'd9;
    #1;
    checks++; if (bus.lq_count !== 3'd0) begin failures++; $display("FAIL rm_count got=%0d exp=0", bus.lq_count); end
    checks++; if (bus.ld_err !== 1'b0) begin failures++; $display("FAIL rm_err got=%b exp=0", bus.ld_err); end
    checks++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b%b exp=00", bus.rs1_busy, bus.rs2_busy); end
    checks++; if (bus.ld_issue_ready !== 1'b1) begin failures++; $display("FAIL rm_issue_ready got=%b exp=1", bus.ld_issue_ready); end
    bus.ld_resp_valid = 1'b1; bus.ld_resp_data = 32'h2;
    tick();
    bus.ld_resp_valid = 1'b0;
    checks++; if (bus.wb_reg_write !== 1'b0 || bus.ld_err !== 1'b1) begin failures++; $display("FAIL rm_stale_resp got=%b/%b exp=0/1", bus.wb_reg_write, bus.ld_err); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_collision();
    test_queue_full();
    test_hazard();
    test_x0();
    test_back_to_back();
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
